myo_spi_responder: RTL and testbench

- SPI slave implementing the motor-board end of the myocontrol SPI link; answers frames issued by the myocontrol master.
- Used as an on-FPGA loopback and emulation target, so myocontrol firmware and the HPS driver can be exercised without motor boards attached.
- Received words are delivered as a valid-strobed stream.
- Reply words are snapshot from a parallel status vector when each frame starts.

---
 rtl/myo_spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/myo_spi_responder.sv | 185 ++++++++++++++++++
 tb/tb_myo_spi_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// Shared definitions for the myocontrol SPI link: word geometry defaults,
// responder FSM states and the SPI mode used by both ends of the link.
package myo_spi_pkg;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 12;
  localparam int DEF_IDX_W     = 4;

  // Mode 1: CPOL=0, CPHA=1. Data launched on SCK rise, sampled on SCK fall.
  localparam logic [1:0] SPI_MODE = 2'd1;
  localparam logic       SPI_CPOL = SPI_MODE[1];
  localparam logic       SPI_CPHA = SPI_MODE[0];
  localparam logic       SAMPLE_ON_FALL = SPI_CPOL ^ SPI_CPHA;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus registered
// single-cycle rise/fall strobes derived from the synchronized level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
    rise_d = sync_q[1] & ~prev_q;
    fall_d = ~sync_q[1] & prev_q;
  end

  // NOTE: non-blocking assignments make every flop sample its pre-edge input,
  // which is what turns the two sync stages into a real two-cycle chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout = sync_q[1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/myo_spi_responder.sv
// Motor-board end of the myocontrol SPI link: receives words as a strobed
// stream and answers each frame with a snapshot of the tx_words vector.
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          sck,
  input  logic                          ss_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [NUM_WORDS*WORD_W-1:0]   tx_words,
  output logic                          rx_valid,
  output logic [WORD_W-1:0]             rx_word,
  output logic [IDX_W-1:0]              rx_index,
  output logic                          frame_done,
  output logic [IDX_W-1:0]              frame_words,
  output logic                          frame_err
);

  localparam int TX_W  = NUM_WORDS * WORD_W;
  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_WORDS);

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;
  logic sck_lvl_unused, ss_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sync_sck (
    .clock(clock), .reset_n(reset_n), .din(sck),
    .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset_n(reset_n), .din(ss_n),
    .dout(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset_n(reset_n), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic sample_stb, launch_stb;
  assign sample_stb = SAMPLE_ON_FALL ? sck_fall : sck_rise;
  assign launch_stb = SAMPLE_ON_FALL ? sck_rise : sck_fall;

  state_e              state_q,       state_d;
  logic [TX_W-1:0]     tx_buf_q,      tx_buf_d;
  logic [WORD_W-1:0]   tx_shift_q,    tx_shift_d;
  logic [WORD_W-2:0]   rx_shift_q,    rx_shift_d;
  logic [CNT_W-1:0]    bit_cnt_q,     bit_cnt_d;
  logic [IDX_W-1:0]    word_idx_q,    word_idx_d;
  logic [WORD_W-1:0]   rx_word_q,     rx_word_d;
  logic [IDX_W-1:0]    rx_index_q,    rx_index_d;
  logic                rx_valid_q,    rx_valid_d;
  logic [IDX_W-1:0]    frame_words_q, frame_words_d;
  logic                frame_err_q,   frame_err_d;

  logic [WORD_W-1:0] sel_word;
  logic [WORD_W-1:0] rx_next;
  logic              overflow;

  // Past the last snapshot word the select falls through to zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (word_idx_q == IDX_W'(k)) sel_word = tx_buf_q[k*WORD_W +: WORD_W];
    end
  end

  assign rx_next  = {rx_shift_q, mosi_s};
  assign overflow = (word_idx_q == IDX_LIMIT);

  always_comb begin
    // NOTE: every _d starts from its held value so no branch of the case
    // below can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    tx_buf_d      = tx_buf_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    rx_word_d     = rx_word_q;
    rx_index_d    = rx_index_q;
    rx_valid_d    = 1'b0;
    frame_words_d = frame_words_q;
    frame_err_d   = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          tx_buf_d    = tx_words;
          tx_shift_d  = tx_words[WORD_W-1:0];
          rx_shift_d  = '0;
          bit_cnt_d   = '0;
          word_idx_d  = '0;
          frame_err_d = 1'b0;
        end
      end

      ACTIVE: begin
        if (sample_stb) begin
          rx_shift_d = rx_next[WORD_W-2:0];
          if (overflow) frame_err_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (!overflow) begin
              rx_word_d  = rx_next;
              rx_index_d = word_idx_q;
              rx_valid_d = 1'b1;
              word_idx_d = word_idx_q + IDX_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end

        // The first launch edge of each word reloads rather than shifts.
        if (launch_stb) begin
          tx_shift_d = (bit_cnt_q == '0) ? sel_word : {tx_shift_q[WORD_W-2:0], 1'b0};
        end

        // Uses the _d values so a word completing on this cycle is counted.
        if (ss_rise) begin
          state_d       = DONE;
          frame_words_d = word_idx_d;
          if (bit_cnt_d != '0) frame_err_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the tx snapshot is ordinary flops, so it is reset with the rest of
  // the datapath; nothing here maps onto a block RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tx_buf_q      <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      rx_word_q     <= '0;
      rx_index_q    <= '0;
      rx_valid_q    <= 1'b0;
      frame_words_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_buf_q      <= tx_buf_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      rx_word_q     <= rx_word_d;
      rx_index_q    <= rx_index_d;
      rx_valid_q    <= rx_valid_d;
      frame_words_q <= frame_words_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Output enable and frame_done decode straight from the state flop, so a
  // reset drops them without waiting for a clock.
  assign miso_oe     = (state_q == ACTIVE);
  assign miso        = miso_oe & ~overflow & tx_shift_q[WORD_W-1];
  assign frame_done  = (state_q == DONE);
  assign rx_valid    = rx_valid_q;
  assign rx_word     = rx_word_q;
  assign rx_index    = rx_index_q;
  assign frame_words = frame_words_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Directed bench for myo_spi_responder: a mode-1 SPI master running at the
// clock/8 limit, a table of frame scenarios and a few hand-built sequences.
module tb_myo_spi_responder;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 12;
  localparam int IDX_W     = 4;
  localparam int HALF_NS   = 40;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic sck     = 1'b0;
  logic ss_n    = 1'b1;
  logic mosi    = 1'b0;
  logic [NUM_WORDS*WORD_W-1:0] tx_words = '0;

  logic                miso, miso_oe, rx_valid, frame_done, frame_err;
  logic [WORD_W-1:0]   rx_word;
  logic [IDX_W-1:0]    rx_index, frame_words;

  myo_spi_responder #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sck(sck), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_words(tx_words),
    .rx_valid(rx_valid), .rx_word(rx_word), .rx_index(rx_index),
    .frame_done(frame_done), .frame_words(frame_words), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          nw;
    int          xb;
    bit          tight;
    bit          snap;
    bit          set_tx;
    logic [15:0] mosi_base;
    logic [15:0] tx_base;
    int          exp_rx;
    int          exp_fw;
    bit          exp_err;
  } frame_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mosi_w [16];
  logic [15:0] miso_w [16];

  logic [15:0] rx_wq [$];
  int          rx_iq [$];
  int          done_cnt = 0;
  int          fw_cap   = 0;
  bit          fe_cap   = 1'b0;

  always @(negedge clock) begin
    if (rx_valid) begin
      rx_wq.push_back(rx_word);
      rx_iq.push_back(int'(rx_index));
    end
    if (frame_done) begin
      done_cnt++;
      fw_cap = int'(frame_words);
      fe_cap = frame_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mode-1 master: launch on SCK rise, sample MISO at SCK fall.
  task automatic xfer(input int nw, input int xb, input bit tight, input bit snap,
                      input int abort_at, output bit oe_mid, output bit oe_async);
    int total, w, b;
    total    = nw * 16 + xb;
    oe_mid   = 1'b0;
    oe_async = 1'b1;
    ss_n = 1'b0;
    #(2 * HALF_NS);
    for (int i = 0; i < total; i++) begin
      w = i / 16;
      b = 15 - (i % 16);
      if (snap && i == 16) tx_words[3*16 +: 16] = 16'hFFFF;
      sck  = 1'b1;
      mosi = mosi_w[w][b];
      if (i == abort_at) begin
        #(HALF_NS / 2);
        reset_n = 1'b0;
        #1;
        oe_async = miso_oe;
        #(HALF_NS / 2 - 1);
        sck  = 1'b0;
        ss_n = 1'b1;
        return;
      end
      #(HALF_NS);
      if (i == 0) oe_mid = miso_oe;
      miso_w[w][b] = miso;
      sck = 1'b0;
      if (tight && i == total - 1) ss_n = 1'b1;
      #(HALF_NS);
    end
    ss_n = 1'b1;
    #(16 * 10);
  endtask

  task automatic run_check(input string tag, input frame_t f);
    logic [15:0] exp_tx [NUM_WORDS];
    logic [15:0] exp_miso;
    int d0;
    bit oe_mid, oe_async;
    if (f.set_tx)
      for (int k = 0; k < NUM_WORDS; k++) tx_words[k*16 +: 16] = f.tx_base + 16'(k);
    for (int k = 0; k < NUM_WORDS; k++) exp_tx[k] = tx_words[k*16 +: 16];
    for (int w = 0; w < 16; w++) mosi_w[w] = f.mosi_base + 16'(w + 1);
    rx_wq.delete();
    rx_iq.delete();
    d0 = done_cnt;
    xfer(f.nw, f.xb, f.tight, f.snap, -1, oe_mid, oe_async);
    check({tag, ".oe_active"}, 32'(oe_mid), 32'd1);
    check({tag, ".rx_count"}, 32'(rx_wq.size()), 32'(f.exp_rx));
    for (int i = 0; i < rx_wq.size() && i < f.exp_rx; i++) begin
      check($sformatf("%s.rx_word[%0d]", tag, i), 32'(rx_wq[i]), 32'(f.mosi_base + 16'(i + 1)));
      check($sformatf("%s.rx_index[%0d]", tag, i), 32'(rx_iq[i]), 32'(i));
    end
    for (int w = 0; w < f.nw; w++) begin
      exp_miso = (w < NUM_WORDS) ? exp_tx[w] : 16'h0000;
      check($sformatf("%s.miso[%0d]", tag, w), 32'(miso_w[w]), 32'(exp_miso));
    end
    check({tag, ".frame_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, ".frame_words"}, 32'(fw_cap), 32'(f.exp_fw));
    check({tag, ".frame_err"}, 32'(fe_cap), 32'(f.exp_err));
    check({tag, ".frame_err_sticky"}, 32'(frame_err), 32'(f.exp_err));
    check({tag, ".idle_oe_miso"}, {30'd0, miso_oe, miso}, 32'd0);
  endtask

  frame_t tbl [6];
  frame_t post;
  int     d0;
  bit     oe_mid, oe_async;

  initial begin
    //            nw xb tight snap set_tx mosi_base tx_base  rx fw err
    tbl[0] = '{12, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hA500, 12, 12, 1'b0};
    tbl[1] = '{ 2, 7, 1'b0, 1'b0, 1'b1, 16'h1230, 16'h5A00,  2,  2, 1'b1};
    tbl[2] = '{14, 0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'hC300, 12, 12, 1'b1};
    tbl[3] = '{ 1, 0, 1'b1, 1'b0, 1'b1, 16'hBEE0, 16'h0F00,  1,  1, 1'b0};
    tbl[4] = '{ 6, 0, 1'b0, 1'b1, 1'b1, 16'h2000, 16'h7700,  6,  6, 1'b0};
    tbl[5] = '{ 6, 0, 1'b0, 1'b0, 1'b0, 16'h2100, 16'h0000,  6,  6, 1'b0};
    post   = '{12, 0, 1'b0, 1'b0, 1'b1, 16'h4000, 16'h3300, 12, 12, 1'b0};

    repeat (3) @(negedge clock);
    check("reset.flags", {27'd0, miso, miso_oe, rx_valid, frame_done, frame_err}, 32'd0);
    check("reset.rx_word", 32'(rx_word), 32'd0);
    check("reset.idx_words", {24'd0, rx_index, frame_words}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    for (int t = 0; t < 6; t++) run_check($sformatf("frame%0d", t), tbl[t]);
    check("snapshot.next_frame_word3", 32'(miso_w[3]), 32'h0000FFFF);

    // SCK toggling with the slave deselected must be ignored.
    rx_wq.delete();
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      sck  = 1'b1;
      mosi = 1'($urandom);
      #(HALF_NS);
      sck = 1'b0;
      #(HALF_NS);
    end
    repeat (8) @(negedge clock);
    check("idle_sck.rx_count", 32'(rx_wq.size()), 32'd0);
    check("idle_sck.frame_done", 32'(done_cnt - d0), 32'd0);

    // Reset during bit 9 of word 5.
    for (int k = 0; k < NUM_WORDS; k++) tx_words[k*16 +: 16] = 16'h6600 + 16'(k);
    for (int w = 0; w < 16; w++) mosi_w[w] = 16'h5000 + 16'(w + 1);
    rx_wq.delete();
    d0 = done_cnt;
    xfer(12, 0, 1'b0, 1'b0, 5 * 16 + 9, oe_mid, oe_async);
    check("rst_mid.oe_async", 32'(oe_async), 32'd0);
    repeat (3) @(negedge clock);
    check("rst_mid.rx_count", 32'(rx_wq.size()), 32'd5);
    check("rst_mid.flags", {27'd0, miso, miso_oe, rx_valid, frame_done, frame_err}, 32'd0);
    check("rst_mid.rx_word", 32'(rx_word), 32'd0);
    check("rst_mid.idx_words", {24'd0, rx_index, frame_words}, 32'd0);
    check("rst_mid.no_frame_done", 32'(done_cnt - d0), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    run_check("post_reset", post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
